lzc_scan: RTL and testbench

- Sequential set-bit iterator built on leading/trailing-zero priority logic.
- Accepts a WIDTH-bit vector over a valid/ready handshake and emits, one beat per handshake, the index of each set bit in priority order (LSB-first or MSB-first), clearing each bit as it is emitted.
- Used wherever a request mask must be serviced one index at a time, e.g. pending-interrupt, pending-writeback or free-list scanning.

---
 rtl/lzc_scan.sv | 133 +++++++++++++
 tb/tb_lzc_scan.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzc_scan.sv
// lzc_scan: set-bit iterator, one index per beat, LSB- or MSB-first.
// Define LZC_SCAN_STATS_EN to add the saturating beat_cnt_o counter.
module lzc_scan #(
  parameter int unsigned WIDTH     = 32,
  parameter logic        MODE      = 1'b0,
  parameter int unsigned CNT_WIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [WIDTH-1:0]     in_data_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [CNT_WIDTH-1:0] out_idx_o,
  output logic [CNT_WIDTH-1:0] out_num_o,
  output logic                 out_last_o,
  output logic                 out_empty_o,
  output logic                 busy_o
`ifdef LZC_SCAN_STATS_EN
  ,
  output logic [31:0]          beat_cnt_o
`endif
);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     mask_q;
  logic [WIDTH-1:0]     mask_d;
  logic [CNT_WIDTH-1:0] num_q;
  logic [CNT_WIDTH-1:0] num_d;
  logic                 zero_q;

  logic [CNT_WIDTH-1:0] idx;
  logic                 single;
  logic                 last;
  logic                 scan;
  logic                 hs;
  logic                 accept;

  // Priority encoder: first set bit of the mask in scan order
  always_comb begin
    idx = '0;
    if (MODE == 1'b0) begin
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (mask_q[i]) idx = CNT_WIDTH'(i);
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (mask_q[i]) idx = CNT_WIDTH'(i);
      end
    end
  end

  // At most one bit left means this beat ends the vector
  assign single = ~|(mask_q & (mask_q - WIDTH'(1)));
  assign last   = zero_q | single;

  assign scan   = (state_q == SCAN) & ~rst_i;
  assign hs     = scan & out_ready_i;
  assign accept = in_valid_i & in_ready_o;

  assign mask_d = mask_q & ~(WIDTH'(1) << idx);
  assign num_d  = num_q + CNT_WIDTH'(1);

  // Ready in IDLE, or on the last-beat handshake for a bubble-free reload
  assign in_ready_o  = ~rst_i & ~flush_i &
                       (~scan | (hs & last));
  assign out_valid_o = scan;
  assign out_idx_o   = scan ? idx : '0;
  assign out_num_o   = scan ? num_q : '0;
  assign out_last_o  = scan & last;
  assign out_empty_o = scan & zero_q;
  assign busy_o      = scan;

  // Scan FSM: load on accept, retire one bit per handshake
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      num_q   <= '0;
      zero_q  <= 1'b0;
    end else if (accept) begin
      state_q <= SCAN;
      mask_q  <= in_data_i;
      num_q   <= '0;
      zero_q  <= ~|in_data_i;
    end else if (hs) begin
      mask_q <= mask_d;
      num_q  <= num_d;
      if (last) begin
        state_q <= IDLE;
        zero_q  <= 1'b0;
      end
    end
  end

`ifdef LZC_SCAN_STATS_EN
  logic [31:0] beat_cnt_q;

  // Saturating count of completed beats, survives flush
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt_q <= '0;
    end else if (hs && !flush_i && beat_cnt_q != '1) begin
      beat_cnt_q <= beat_cnt_q + 32'd1;
    end
  end

  assign beat_cnt_o = beat_cnt_q;
`endif

`ifndef SYNTHESIS
  if (WIDTH < 1) begin : g_width_chk
    $error("lzc_scan: WIDTH must be >= 1");
  end

  a_valid_hold: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i && !flush_i) |=> out_valid_o
  );

  a_beat_stable: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i && !flush_i) |=>
      ($stable(out_idx_o) && $stable(out_num_o) &&
       $stable(out_last_o) && $stable(out_empty_o))
  );
`endif

endmodule

// File: tb/tb_lzc_scan.sv
// tb_lzc_scan: scoreboard bench for lzc_scan, both scan orders plus WIDTH=1.
// Beats are modelled per vector and popped as the DUT hands them out.
module tb_lzc_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, flush, in_valid, out_ready;
  logic [7:0] in_data;
  logic       in_ready0, in_ready1;
  logic       out_valid0, out_valid1;
  logic [2:0] idx0, idx1, num0, num1;
  logic       last0, last1, empty0, empty1;
  logic       busy0, busy1;

  logic       in_valid2, in_data2, in_ready2, out_valid2;
  logic       idx2, num2, last2, empty2, busy2;

`ifdef LZC_SCAN_STATS_EN
  logic [31:0] cnt0, cnt1, cnt2;
`endif

  lzc_scan #(.WIDTH(8), .MODE(1'b0)) dut0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready0),
    .in_data_i(in_data), .out_valid_o(out_valid0),
    .out_ready_i(out_ready), .out_idx_o(idx0),
    .out_num_o(num0), .out_last_o(last0),
    .out_empty_o(empty0), .busy_o(busy0)
`ifdef LZC_SCAN_STATS_EN
    , .beat_cnt_o(cnt0)
`endif
  );

  lzc_scan #(.WIDTH(8), .MODE(1'b1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready1),
    .in_data_i(in_data), .out_valid_o(out_valid1),
    .out_ready_i(out_ready), .out_idx_o(idx1),
    .out_num_o(num1), .out_last_o(last1),
    .out_empty_o(empty1), .busy_o(busy1)
`ifdef LZC_SCAN_STATS_EN
    , .beat_cnt_o(cnt1)
`endif
  );

  lzc_scan #(.WIDTH(1), .MODE(1'b0)) dut2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid2), .in_ready_o(in_ready2),
    .in_data_i(in_data2), .out_valid_o(out_valid2),
    .out_ready_i(out_ready), .out_idx_o(idx2),
    .out_num_o(num2), .out_last_o(last2),
    .out_empty_o(empty2), .busy_o(busy2)
`ifdef LZC_SCAN_STATS_EN
    , .beat_cnt_o(cnt2)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int pops0 = 0;

  // beat record: {idx[2:0], num[2:0], last, empty}
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected beats of one vector in both scan orders
  function automatic void push_exp(input logic [7:0] v);
    for (int m = 0; m < 2; m++) begin
      logic [7:0] r;
      logic [7:0] e;
      int n;
      int p;
      r = v;
      n = 0;
      if (r == 8'h00) begin
        e = 8'b000_000_1_1;
        if (m == 0) q0.push_back(e);
        else q1.push_back(e);
      end
      while (r != 8'h00) begin
        p = -1;
        for (int i = 0; i < 8; i++)
          if (r[i] && (p < 0 || m == 1)) p = i;
        e = {3'(p), 3'(n), $countones(r) == 1, 1'b0};
        if (m == 0) q0.push_back(e);
        else q1.push_back(e);
        r[p] = 1'b0;
        n++;
      end
    end
  endfunction

  // Pop and compare every completed beat
  always @(negedge clk) begin
    if (!rst && !flush && out_ready) begin
      if (out_valid0) begin
        pops0++;
        if (q0.size() == 0) chk("extra beat lsb", 1, 0);
        else chk("beat lsb", {idx0, num0, last0, empty0},
                 q0.pop_front());
      end
      if (out_valid1) begin
        if (q1.size() == 0) chk("extra beat msb", 1, 0);
        else chk("beat msb", {idx1, num1, last1, empty1},
                 q1.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] v, output bit with_last);
    int t;
    t = 0;
    with_last = 1'b0;
    in_valid = 1'b1;
    in_data = v;
    push_exp(v);
    while (1) begin
      @(negedge clk);
      if (in_ready0) break;
      t++;
      if (t > 200) begin
        chk("accept timeout", 1, 0);
        break;
      end
    end
    with_last = out_valid0 & last0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q0.size() != 0 || q1.size() != 0 || busy0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("drain timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    int         nbeats;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    bit   wl;
    int   p;

    tbl[0] = '{8'hA4, 3};
    tbl[1] = '{8'h00, 1};
    tbl[2] = '{8'h01, 1};
    tbl[3] = '{8'h80, 1};
    tbl[4] = '{8'hFF, 8};
    tbl[5] = '{8'h5A, 4};
    tbl[6] = '{8'h0F, 4};
    tbl[7] = '{8'h30, 2};

    rst = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b1;
    in_valid2 = 1'b0;
    in_data2 = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outs lsb", {in_ready0, out_valid0, idx0, num0,
                           last0, empty0, busy0}, 0);
    chk("reset outs msb", {in_ready1, out_valid1, idx1, num1,
                           last1, empty1, busy1}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle after reset", {out_valid0, busy0, in_ready0}, 3'b001);
    @(posedge clk);
    #1;

    // WIDTH=1: a one gives one last beat, a zero one empty beat
    in_valid2 = 1'b1;
    in_data2 = 1'b1;
    @(negedge clk);
    chk("w1 ready", in_ready2, 1);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    @(negedge clk);
    chk("w1 one beat", {out_valid2, idx2, num2, last2, empty2},
        5'b1_0_0_1_0);
    @(posedge clk);
    #1;
    in_valid2 = 1'b1;
    in_data2 = 1'b0;
    @(negedge clk);
    chk("w1 done", {out_valid2, in_ready2}, 2'b01);
    @(posedge clk);
    #1;
    in_valid2 = 1'b0;
    @(negedge clk);
    chk("w1 zero beat", {out_valid2, idx2, num2, last2, empty2},
        5'b1_0_0_1_1);
    @(posedge clk);
    #1;

    // First beat one cycle after accept
    send(8'hA4, wl);
    @(negedge clk);
    chk("A4 first lsb", {out_valid0, idx0, num0, last0},
        {1'b1, 3'd2, 3'd0, 1'b0});
    chk("A4 first msb", {out_valid1, idx1, num1, last1},
        {1'b1, 3'd7, 3'd0, 1'b0});
    @(posedge clk);
    #1;
    drain();

    for (int k = 0; k < 8; k++) begin
      p = pops0;
      send(tbl[k].data, wl);
      drain();
      chk("beat count", pops0 - p, tbl[k].nbeats);
      @(negedge clk);
      chk("back to idle", {in_ready0, busy0, in_ready1, busy1},
          4'b1010);
      @(posedge clk);
      #1;
    end

    // Backpressure on first beat, then bubble-free reload
    send(8'h81, wl);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall lsb", {out_valid0, idx0, num0, last0},
          {1'b1, 3'd0, 3'd0, 1'b0});
      chk("stall msb", {out_valid1, idx1}, {1'b1, 3'd7});
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'h02, wl);
    chk("accept on last beat", wl, 1);
    @(negedge clk);
    chk("no bubble", {out_valid0, idx0, num0, last0},
        {1'b1, 3'd1, 3'd0, 1'b1});
    @(posedge clk);
    #1;
    drain();

    // flush in IDLE only drops in_ready
    flush = 1'b1;
    @(negedge clk);
    chk("flush idle ready", {in_ready0, busy0}, 2'b00);
    @(posedge clk);
    #1;
    flush = 1'b0;

    // Flush after three beats
    p = pops0;
    send(8'hFF, wl);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    q0.delete();
    q1.delete();
    chk("beats before flush", pops0 - p, 3);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("after flush", {out_valid0, busy0, in_ready0,
                        out_valid1, busy1}, 5'b00100);
    @(posedge clk);
    #1;

    // Reset after three beats
    send(8'hFF, wl);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    @(negedge clk);
    chk("mid-scan reset outs", {in_ready0, out_valid0, idx0, num0,
                                last0, empty0, busy0}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after reset", {out_valid0, busy0, in_ready0}, 3'b001);
    @(posedge clk);
    #1;

`ifdef LZC_SCAN_STATS_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h0F, wl);
    drain();
    send(8'h00, wl);
    drain();
    send(8'h30, wl);
    drain();
    chk("beat_cnt", cnt0, 32'd7);
    force dut0.beat_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut0.beat_cnt_q;
    send(8'h07, wl);
    drain();
    chk("beat_cnt sat", cnt0, 32'hFFFF_FFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
